// File: rtl/mem_initiator_pkg.sv
// Shared types and default sizing for the mem_initiator memory driver.
// The optional write-acknowledge beat is enabled with MEM_INITIATOR_WR_ACK_EN.
package mem_initiator_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        RSP      = 3'd4
    } state_t;

endpackage

// File: rtl/mem_initiator.sv
// Valid/ready front end for a single-port registered-read memory: single writes and
// 1..16 beat incrementing read bursts. Define MEM_INITIATOR_WR_ACK_EN to return a write ack beat.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_last,
    output logic              mem_rden,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [LEN_W-1:0]    beat_reg, beat_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;

    logic                req_ready_next;
    logic                rsp_valid_next;
    logic [DATA_W-1:0]   rsp_rdata_next;
    logic [ADDR_W-1:0]   rsp_addr_next;
    logic                rsp_last_next;
    logic                mem_rden_next;
    logic                mem_wren_next;
    logic [ADDR_W-1:0]   mem_addr_next;
    logic [DATA_W-1:0]   mem_datain_next;

    // State, context and every output are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cur_addr_reg <= '0;
            len_reg      <= '0;
            beat_reg     <= '0;
            wdata_reg    <= '0;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_addr     <= '0;
            rsp_last     <= 1'b0;
            mem_rden     <= 1'b0;
            mem_wren     <= 1'b0;
            mem_addr     <= '0;
            mem_datain   <= '0;
        end else begin
            state_reg    <= state_next;
            cur_addr_reg <= cur_addr_next;
            len_reg      <= len_next;
            beat_reg     <= beat_next;
            wdata_reg    <= wdata_next;
            req_ready    <= req_ready_next;
            rsp_valid    <= rsp_valid_next;
            rsp_rdata    <= rsp_rdata_next;
            rsp_addr     <= rsp_addr_next;
            rsp_last     <= rsp_last_next;
            mem_rden     <= mem_rden_next;
            mem_wren     <= mem_wren_next;
            mem_addr     <= mem_addr_next;
            mem_datain   <= mem_datain_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cur_addr_next = cur_addr_reg;
        len_next      = len_reg;
        beat_next     = beat_reg;
        wdata_next    = wdata_reg;
        case (state_reg)
            IDLE: begin
                // req_ready is still low in the first cycle after reset release.
                if (req_valid && req_ready) begin
                    cur_addr_next = req_addr;
                    if (req_write) begin
                        wdata_next = req_wdata;
                        state_next = WR;
                    end else begin
                        len_next   = req_len;
                        beat_next  = '0;
                        state_next = RD_ISSUE;
                    end
                end
            end
            WR: begin
`ifdef MEM_INITIATOR_WR_ACK_EN
                state_next = RSP;
`else
                state_next = IDLE;
`endif
            end
            RD_ISSUE: state_next = RD_WAIT;
            RD_WAIT:  state_next = RSP;
            RSP: begin
                if (rsp_ready) begin
                    if (rsp_last) begin
                        state_next = IDLE;
                    end else begin
                        cur_addr_next = cur_addr_reg + ADDR_W'(1);
                        beat_next     = beat_reg + LEN_W'(1);
                        state_next    = RD_ISSUE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it after the edge.
    always_comb begin
        req_ready_next  = (state_next == IDLE);
        rsp_valid_next  = (state_next == RSP);
        mem_rden_next   = (state_next == RD_ISSUE);
        mem_wren_next   = (state_next == WR);
        mem_addr_next   = mem_addr;
        mem_datain_next = mem_datain;
        rsp_rdata_next  = rsp_rdata;
        rsp_addr_next   = rsp_addr;
        rsp_last_next   = rsp_last;

        if (mem_rden_next || mem_wren_next) begin
            mem_addr_next = cur_addr_next;
        end
        if (mem_wren_next) begin
            mem_datain_next = wdata_next;
        end

        if (state_reg == RD_WAIT) begin
            rsp_rdata_next = mem_dataout;
            rsp_addr_next  = cur_addr_reg;
            rsp_last_next  = (beat_reg == len_reg);
        end
`ifdef MEM_INITIATOR_WR_ACK_EN
        if (state_reg == WR) begin
            rsp_rdata_next = '0;
            rsp_addr_next  = cur_addr_reg;
            rsp_last_next  = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed self-checking bench for mem_initiator with a 16x32 registered-read memory model.
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_addr, req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_last;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_addr;
    logic        mem_rden, mem_wren;
    logic [3:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;

    logic [31:0] mem [16];
    logic [31:0] exp_mem [16];

    int vectors = 0;
    int miscompares = 0;
    int rden_cnt = 0, wren_cnt = 0, both_cnt = 0, acc_cnt = 0, rsp_cnt = 0;

    always #5 clk = ~clk;

    mem_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_addr(rsp_addr), .rsp_last(rsp_last),
        .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_datain(mem_datain), .mem_dataout(mem_dataout)
    );

    // Memory with one-cycle registered read.
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_datain;
        if (mem_rden) mem_dataout <= mem[mem_addr];
    end

    always @(posedge clk) begin
        if (mem_rden) rden_cnt++;
        if (mem_wren) wren_cnt++;
        if (mem_rden && mem_wren) both_cnt++;
        if (req_valid && req_ready) acc_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) chk("ready_timeout", {63'd0, req_ready}, 64'd1);
    endtask

    // Checks from the cycle after a write handshake onward.
    task automatic finish_write(input logic [3:0] a, input logic [31:0] d);
        int r0;
        r0 = rsp_cnt;
        chk("wr_strobe", mem_wren, 1);
        chk("wr_addr", mem_addr, a);
        chk("wr_data", mem_datain, d);
        chk("wr_rden_low", mem_rden, 0);
        chk("wr_busy", req_ready, 0);
        step();
        chk("wr_single", mem_wren, 0);
        chk("wr_addr_hold", mem_addr, a);
`ifdef MEM_INITIATOR_WR_ACK_EN
        chk("ack_valid", rsp_valid, 1);
        chk("ack_addr", rsp_addr, a);
        chk("ack_last", rsp_last, 1);
        chk("ack_rdata", rsp_rdata, 0);
        chk("ack_no_ready", req_ready, 0);
        step();
        chk("ack_drop", rsp_valid, 0);
        chk("ack_ready", req_ready, 1);
        chk("ack_count", rsp_cnt - r0, 1);
`else
        chk("wr_ready_again", req_ready, 1);
        repeat (3) step();
        chk("wr_silent", rsp_cnt - r0, 0);
`endif
        exp_mem[a] = d;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        wait_ready();
        req_valid = 1; req_write = 1; req_addr = a; req_wdata = d;
        step();
        req_valid = 0;
        finish_write(a, d);
    endtask

    // Cycle-exact read burst; optional stall on one beat; busy=1 keeps req_valid asserted.
    task automatic read_burst(input logic [3:0] a, input logic [3:0] len,
                              input int stall_beat, input bit busy);
        logic [3:0]  ea;
        logic [31:0] d0;
        int          r0;
        wait_ready();
        req_valid = 1; req_write = 0; req_addr = a; req_len = len;
        step();
        if (busy) begin
            req_write = 1; req_addr = 4'd5; req_wdata = 32'h55;
        end else begin
            req_valid = 0;
        end
        for (int i = 0; i <= int'(len); i++) begin
            ea = a + 4'(i);
            chk("rd_strobe", mem_rden, 1);
            chk("rd_addr", mem_addr, ea);
            chk("rd_no_ready", req_ready, 0);
            step();
            chk("rd_strobe_off", mem_rden, 0);
            chk("rd_valid_early", rsp_valid, 0);
            step();
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_rdata", rsp_rdata, exp_mem[ea]);
            chk("rsp_addr", rsp_addr, ea);
            chk("rsp_last", rsp_last, (i == int'(len)));
            if (busy) chk("busy_no_ready", req_ready, 0);
            if (i == stall_beat) begin
                rsp_ready = 0;
                r0 = rden_cnt;
                d0 = rsp_rdata;
                repeat (5) begin
                    step();
                    chk("stall_valid", rsp_valid, 1);
                    chk("stall_rdata", rsp_rdata, d0);
                    chk("stall_addr", rsp_addr, ea);
                end
                chk("stall_no_rden", rden_cnt - r0, 0);
                rsp_ready = 1;
            end
            step();
        end
        chk("burst_end_valid", rsp_valid, 0);
        chk("burst_end_ready", req_ready, 1);
        chk("burst_end_rden", mem_rden, 0);
    endtask

    initial begin
        int a0, w0, r0;
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_len = 0;
        req_wdata = 0; rsp_ready = 1;
        step(); step();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_datain", mem_datain, 0);
        rst_n = 1;
        step();
        chk("ready_after_reset", req_ready, 1);

        // Write then single-beat read.
        do_write(4'd3, 32'hDEADBEEF);
        read_burst(4'd3, 4'd0, -1, 0);

        // Wrapping burst 14,15,0,1.
        do_write(4'd14, 32'hA0);
        do_write(4'd15, 32'hA1);
        do_write(4'd0, 32'hA2);
        do_write(4'd1, 32'hA3);
        read_burst(4'd14, 4'd3, -1, 0);

        // Backpressure on the second beat.
        read_burst(4'd14, 4'd3, 1, 0);

        // Request held during a burst; the pending write is taken once afterwards.
        a0 = acc_cnt; w0 = wren_cnt;
        read_burst(4'd0, 4'd3, -1, 1);
        step();
        req_valid = 0;
        finish_write(4'd5, 32'h55);
        chk("busy_accept_once", acc_cnt - a0, 2);
        chk("busy_write_once", wren_cnt - w0, 1);
        read_burst(4'd5, 4'd0, -1, 0);

        // Reset during the second beat of a 16-beat burst.
        wait_ready();
        req_valid = 1; req_write = 0; req_addr = 4'd0; req_len = 4'd15;
        step();
        req_valid = 0;
        step(); step();
        chk("mid_beat0_data", rsp_rdata, 32'hA2);
        step(); step(); step();
        chk("mid_beat1_valid", rsp_valid, 1);
        chk("mid_beat1_data", rsp_rdata, 32'hA3);
        #2 rst_n = 0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        chk("abort_rden", mem_rden, 0);
        chk("abort_mem_addr", mem_addr, 0);
        chk("abort_req_ready", req_ready, 0);
        r0 = rden_cnt;
        repeat (3) step();
        chk("abort_no_rden", rden_cnt - r0, 0);
        rst_n = 1;
        step();
        chk("abort_ready", req_ready, 1);
        chk("abort_quiet", rsp_valid, 0);

        // Write ack behaviour (or silence) for addr 9.
        do_write(4'd9, 32'h12345678);
        read_burst(4'd9, 4'd0, -1, 0);

        chk("strobe_exclusive", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
